// File: rtl/dma_channel_arbiter.sv
// ----------------------------------------------------------------------------
// dma_channel_arbiter
//
// Arbitrates four DMA channel requests for the single shared transfer engine.
// It runs the HRQ/HLDA bus-hold handshake with the CPU, drives the one-hot
// channel acknowledge (DACK), reports the granted channel to the sequencer,
// and accepts the sequencer's end-of-service pulse back.
//
// Ports:
//   CLK              system clock
//   RESET            synchronous, active-high reset
//   DREQ[3:0]        raw channel requests (polarity per dreqActiveLow)
//   dreqActiveLow    1: DREQ active-low, 0: active-high
//   dackActiveHigh   1: DACK active-high, 0: active-low
//   maskReg[3:0]     1 = channel masked
//   rotatingPriority 1: rotating priority, 0: fixed (ch0 highest)
//   arbEnable        0 = controller disabled, no new requests raised
//   autoInit[3:0]    per-channel autoinitialize enable
//   HLDA             hold acknowledge from CPU
//   serviceDone      1-cycle pulse: current transfer finished
//   terminalCount    qualifies serviceDone: word count expired
//   HRQ              hold request to CPU
//   DACK[3:0]        channel acknowledge, polarity per dackActiveHigh
//   activeChannel    granted channel index
//   grantValid       grant in progress, DACK asserted
//   maskSet[3:0]     1-cycle pulse: set mask bit of the served channel
//   reqStatus[3:0]   effective pending requests
// ----------------------------------------------------------------------------
module dma_channel_arbiter #(
   parameter int NUM_CH = 4
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [NUM_CH-1:0]          DREQ,
   input  logic                       dreqActiveLow,
   input  logic                       dackActiveHigh,
   input  logic [NUM_CH-1:0]          maskReg,
   input  logic                       rotatingPriority,
   input  logic                       arbEnable,
   input  logic [NUM_CH-1:0]          autoInit,
   input  logic                       HLDA,
   input  logic                       serviceDone,
   input  logic                       terminalCount,
   output logic                       HRQ,
   output logic [NUM_CH-1:0]          DACK,
   output logic [$clog2(NUM_CH)-1:0]  activeChannel,
   output logic                       grantValid,
   output logic [NUM_CH-1:0]          maskSet,
   output logic [NUM_CH-1:0]          reqStatus
);

   localparam int CH_W = $clog2(NUM_CH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_GRANTED,
      ST_RELEASE
   } state_t;

   state_t             r_state;
   logic               r_hrq;
   logic [NUM_CH-1:0]  r_dack;
   logic [CH_W-1:0]    r_active;
   logic               r_grant_valid;
   logic [NUM_CH-1:0]  r_mask_set;
   logic [NUM_CH-1:0]  r_req_status;
   logic [CH_W-1:0]    r_ptr;

   logic [NUM_CH-1:0]  w_eff_req;
   logic [NUM_CH-1:0]  w_dack_flip;
   logic [CH_W-1:0]    w_base;
   logic [CH_W-1:0]    w_winner;

   function automatic logic [NUM_CH-1:0] f_onehot(input logic [CH_W-1:0] ch);
      f_onehot     = '0;
      f_onehot[ch] = 1'b1;
   endfunction

   // Requests normalised to active-high and with masked channels removed.
   assign w_eff_req   = (DREQ ^ {NUM_CH{dreqActiveLow}}) & ~maskReg;
   // XOR mask converting an active-high one-hot into the DACK pin polarity;
   // it is also the all-inactive DACK value.
   assign w_dack_flip = {NUM_CH{~dackActiveHigh}};
   // Fixed mode is rotating mode with the search anchored at channel 0.
   assign w_base      = rotatingPriority ? r_ptr : '0;

   // Scan from the lowest priority position down to the highest so the last
   // hit, i.e. the first channel in search order, is the one that sticks.
   always_comb begin
      // NOTE: default assignment before the loop so every path drives
      // w_winner; without it synthesis would infer a latch.
      w_winner = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (w_eff_req[w_base + CH_W'(k)]) begin
            w_winner = w_base + CH_W'(k);
         end
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= ST_IDLE;
         r_hrq         <= 1'b0;
         r_dack        <= w_dack_flip;
         r_active      <= '0;
         r_grant_valid <= 1'b0;
         r_mask_set    <= '0;
         r_req_status  <= '0;
         r_ptr         <= '0;
      end else begin
         r_req_status <= w_eff_req;
         r_mask_set   <= '0;

         case (r_state)
            ST_IDLE: begin
               r_hrq         <= 1'b0;
               r_grant_valid <= 1'b0;
               r_dack        <= w_dack_flip;
               if (arbEnable && (|w_eff_req)) begin
                  r_state <= ST_REQUEST;
                  r_hrq   <= 1'b1;
               end
            end

            ST_REQUEST: begin
               // HRQ is never withdrawn before the CPU answers.
               r_hrq         <= 1'b1;
               r_grant_valid <= 1'b0;
               r_dack        <= w_dack_flip;
               if (HLDA) begin
                  if (|w_eff_req) begin
                     r_state       <= ST_GRANTED;
                     r_active      <= w_winner;
                     r_dack        <= f_onehot(w_winner) ^ w_dack_flip;
                     r_grant_valid <= 1'b1;
                  end else begin
                     // Request vanished while waiting: hand the bus back.
                     r_state <= ST_RELEASE;
                     r_hrq   <= 1'b0;
                  end
               end
            end

            ST_GRANTED: begin
               // Channel is locked: DREQ, maskReg and arbEnable are ignored.
               r_hrq         <= 1'b1;
               r_grant_valid <= 1'b1;
               r_dack        <= f_onehot(r_active) ^ w_dack_flip;
               if (!HLDA) begin
                  // CPU took the bus back mid-service: abort quietly.
                  r_state       <= ST_RELEASE;
                  r_hrq         <= 1'b0;
                  r_grant_valid <= 1'b0;
                  r_dack        <= w_dack_flip;
               end else if (serviceDone) begin
                  r_state       <= ST_RELEASE;
                  r_hrq         <= 1'b0;
                  r_grant_valid <= 1'b0;
                  r_dack        <= w_dack_flip;
                  if (terminalCount && !autoInit[r_active]) begin
                     r_mask_set <= f_onehot(r_active);
                  end
                  if (rotatingPriority) begin
                     // Served channel drops to lowest priority.
                     r_ptr <= r_active + CH_W'(1);
                  end
               end
            end

            ST_RELEASE: begin
               r_hrq         <= 1'b0;
               r_grant_valid <= 1'b0;
               r_dack        <= w_dack_flip;
               if (!HLDA) begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign HRQ           = r_hrq;
   assign DACK          = r_dack;
   assign activeChannel = r_active;
   assign grantValid    = r_grant_valid;
   assign maskSet       = r_mask_set;
   assign reqStatus     = r_req_status;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dma_channel_arbiter
//
// The bench plays CPU and sequencer. Each transaction pushes the expected
// grant and release into a scoreboard queue; an independent monitor pops and
// compares whenever grantValid rises or falls, and checks the DACK/maskSet
// invariants every cycle. Inputs are driven and outputs sampled on negedges.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dma_channel_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] DREQ;
   logic       dreqActiveLow;
   logic       dackActiveHigh;
   logic [3:0] maskReg;
   logic       rotatingPriority;
   logic       arbEnable;
   logic [3:0] autoInit;
   logic       HLDA;
   logic       serviceDone;
   logic       terminalCount;
   logic       HRQ;
   logic [3:0] DACK;
   logic [1:0] activeChannel;
   logic       grantValid;
   logic [3:0] maskSet;
   logic [3:0] reqStatus;

   always #5 CLK = ~CLK;

   dma_channel_arbiter #(.NUM_CH(4)) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .DREQ             (DREQ),
      .dreqActiveLow    (dreqActiveLow),
      .dackActiveHigh   (dackActiveHigh),
      .maskReg          (maskReg),
      .rotatingPriority (rotatingPriority),
      .arbEnable        (arbEnable),
      .autoInit         (autoInit),
      .HLDA             (HLDA),
      .serviceDone      (serviceDone),
      .terminalCount    (terminalCount),
      .HRQ              (HRQ),
      .DACK             (DACK),
      .activeChannel    (activeChannel),
      .grantValid       (grantValid),
      .maskSet          (maskSet),
      .reqStatus        (reqStatus)
   );

   typedef struct {
      bit         is_grant;
      logic [1:0] ch;
      logic [3:0] dack;
      logic [3:0] mset;
   } exp_t;

   exp_t       exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [1:0] ptr_m = 2'd0;   // model of the rotating priority pointer
   bit         mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [3:0] onehot(input logic [1:0] ch);
      logic [3:0] v;
      v = 4'b0001 << ch;
      return v;
   endfunction

   // Search order: fixed starts at ch0, rotating starts at the pointer; the
   // first requesting channel in that order wins.
   function automatic logic [1:0] ref_winner(input logic [3:0] eff, input bit rot,
                                             input logic [1:0] ptr);
      int start;
      start = rot ? int'(ptr) : 0;
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (start + k) % 4;
         if (eff[idx]) return 2'(idx);
      end
      return 2'd0;
   endfunction

   // ---------------------------------------------------------------- monitor
   logic       pol_q;
   logic       gv_prev = 1'b0;
   logic [1:0] cur_ch  = 2'd0;

   always @(posedge CLK) pol_q <= dackActiveHigh;

   always @(negedge CLK) begin : monitor
      logic [3:0] act;
      exp_t       e;
      bit         fall;
      if (mon_en) begin
         act  = pol_q ? DACK : ~DACK;
         fall = gv_prev && !grantValid;
         if (!gv_prev && grantValid) begin
            check("sb_grant_pending", 32'(exp_q.size() > 0 && exp_q[0].is_grant), 32'd1);
            if (exp_q.size() > 0 && exp_q[0].is_grant) begin
               e = exp_q.pop_front();
               check("grant_channel", 32'(activeChannel), 32'(e.ch));
               check("grant_dack", 32'(DACK), 32'(e.dack));
               cur_ch = e.ch;
            end
         end
         if (fall) begin
            check("sb_release_pending", 32'(exp_q.size() > 0 && !exp_q[0].is_grant), 32'd1);
            if (exp_q.size() > 0 && !exp_q[0].is_grant) begin
               e = exp_q.pop_front();
               check("release_maskset", 32'(maskSet), 32'(e.mset));
               check("release_hrq", 32'(HRQ), 32'd0);
            end
         end else begin
            check("maskset_quiet", 32'(maskSet), 32'd0);
         end
         check("dack_at_most_one", 32'($countones(act) <= 1), 32'd1);
         if (grantValid) begin
            check("dack_on_channel", 32'(act), 32'(onehot(cur_ch)));
            check("channel_locked", 32'(activeChannel), 32'(cur_ch));
         end else begin
            check("dack_inactive", 32'(act), 32'd0);
         end
         gv_prev = grantValid;
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic clean_inputs();
      DREQ             = {4{dreqActiveLow}};
      maskReg          = 4'b0000;
      arbEnable        = 1'b1;
      HLDA             = 1'b0;
      serviceDone      = 1'b0;
      terminalCount    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      clean_inputs();
      @(negedge CLK);
      RESET = 1'b0;
      ptr_m = 2'd0;
   endtask

   task automatic txn(input logic [3:0] raw, input logic [3:0] mask, input bit pol_lo,
                      input bit dack_hi, input bit rot, input logic [3:0] ai,
                      input bit tc, input bit abort, input int hold_req, input int hold_gnt);
      logic [3:0] eff, oh;
      logic [1:0] w;
      eff = (raw ^ {4{pol_lo}}) & ~mask;
      @(negedge CLK);
      DREQ = raw; maskReg = mask; dreqActiveLow = pol_lo; dackActiveHigh = dack_hi;
      rotatingPriority = rot; autoInit = ai; arbEnable = 1'b1; HLDA = 1'b0;
      serviceDone = 1'b0;
      @(negedge CLK);
      check("hrq_rise", 32'(HRQ), 32'd1);
      check("req_status", 32'(reqStatus), 32'(eff));
      w  = ref_winner(eff, rot, ptr_m);
      oh = onehot(w);
      exp_q.push_back('{is_grant: 1'b1, ch: w, dack: (dack_hi ? oh : ~oh), mset: 4'b0000});
      for (int i = 0; i < hold_req; i++) begin
         serviceDone   = 1'($urandom_range(0, 1));   // must be ignored here
         terminalCount = 1'b1;
         @(negedge CLK);
         check("hrq_hold", 32'(HRQ), 32'd1);
      end
      serviceDone = 1'b0;
      HLDA        = 1'b1;
      @(negedge CLK);
      check("grant_latency", 32'(grantValid), 32'd1);
      for (int i = 0; i < hold_gnt; i++) begin
         DREQ      = 4'($urandom);
         maskReg   = 4'($urandom);
         arbEnable = 1'($urandom);
         @(negedge CLK);
         check("hrq_in_grant", 32'(HRQ), 32'd1);
      end
      if (abort) begin
         HLDA = 1'b0;
         exp_q.push_back('{is_grant: 1'b0, ch: 2'd0, dack: 4'b0000, mset: 4'b0000});
      end else begin
         serviceDone   = 1'b1;
         terminalCount = tc;
         exp_q.push_back('{is_grant: 1'b0, ch: 2'd0, dack: 4'b0000,
                           mset: ((tc && !ai[w]) ? oh : 4'b0000)});
         if (rot) ptr_m = w + 2'd1;
      end
      @(negedge CLK);
      serviceDone   = 1'b0;
      terminalCount = 1'($urandom_range(0, 1));
      check("release_latency", 32'(grantValid), 32'd0);
      check("hrq_drop", 32'(HRQ), 32'd0);
      if (!abort) begin
         // Requests are pending but HLDA is still high: no new HRQ yet.
         DREQ = raw; maskReg = mask; arbEnable = 1'b1;
         for (int i = 0; i < hold_req + 1; i++) begin
            @(negedge CLK);
            check("hrq_wait_hlda", 32'(HRQ), 32'd0);
         end
      end
      HLDA      = 1'b0;
      DREQ      = {4{pol_lo}};
      maskReg   = 4'b0000;
      arbEnable = 1'b1;
   endtask

   task automatic rand_txn();
      logic [3:0] eff, mask, raw;
      bit         pol;
      eff  = 4'($urandom_range(1, 15));
      mask = 4'($urandom) & ~eff;
      pol  = 1'($urandom);
      raw  = (eff | (4'($urandom) & mask)) ^ {4{pol}};
      txn(raw, mask, pol, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
          ($urandom_range(0, 7) == 0), $urandom_range(0, 2), $urandom_range(0, 2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d scoreboard entries left", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; dreqActiveLow = 1'b0; dackActiveHigh = 1'b1;
      rotatingPriority = 1'b0; autoInit = 4'b0000;
      clean_inputs();
      repeat (2) @(negedge CLK);
      check("rst_hrq", 32'(HRQ), 32'd0);
      check("rst_grant_valid", 32'(grantValid), 32'd0);
      check("rst_active_channel", 32'(activeChannel), 32'd0);
      check("rst_maskset", 32'(maskSet), 32'd0);
      check("rst_req_status", 32'(reqStatus), 32'd0);
      check("rst_dack", 32'(DACK), 32'h0);
      RESET  = 1'b0;
      mon_en = 1'b1;

      // Disabled controller must not raise HRQ.
      DREQ = 4'b0001; arbEnable = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         check("disabled_no_hrq", 32'(HRQ), 32'd0);
      end
      DREQ = 4'b0000; arbEnable = 1'b1;

      // Single request, fixed priority.
      txn(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 1);
      // Fixed priority: ch1 wins over ch3 every time.
      repeat (3) txn(4'b1010, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1, 1);
      // Rotating with all requesting: 0,1,2,3,0.
      do_reset();
      repeat (5) txn(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 0);
      // Terminal count on ch3 with and without autoinitialize.
      txn(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 1);
      txn(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 0, 1);
      // Active-low request and acknowledge.
      txn(4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 1);
      // Abort by HLDA drop with terminal count pending: no maskSet.
      txn(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 0, 1);

      // Request withdrawn by masking before HLDA: release with no DACK.
      @(negedge CLK);
      DREQ = 4'b1110; dreqActiveLow = 1'b1; dackActiveHigh = 1'b0;
      maskReg = 4'b0000; rotatingPriority = 1'b0; HLDA = 1'b0;
      @(negedge CLK);
      check("wd_hrq", 32'(HRQ), 32'd1);
      maskReg = 4'b0001;
      @(negedge CLK);
      check("wd_hrq_held", 32'(HRQ), 32'd1);
      HLDA = 1'b1;
      @(negedge CLK);
      check("wd_no_grant", 32'(grantValid), 32'd0);
      check("wd_hrq_released", 32'(HRQ), 32'd0);
      check("wd_dack", 32'(DACK), 32'hF);
      HLDA = 1'b0; DREQ = 4'b1111; maskReg = 4'b0000;

      // Reset while granted.
      @(negedge CLK);
      DREQ = 4'b0010; dreqActiveLow = 1'b0; dackActiveHigh = 1'b1;
      rotatingPriority = 1'b0; HLDA = 1'b0;
      @(negedge CLK);
      check("rg_hrq", 32'(HRQ), 32'd1);
      exp_q.push_back('{is_grant: 1'b1, ch: ref_winner(4'b0010, 1'b0, ptr_m),
                        dack: onehot(ref_winner(4'b0010, 1'b0, ptr_m)), mset: 4'b0000});
      HLDA = 1'b1;
      @(negedge CLK);
      check("rg_granted", 32'(grantValid), 32'd1);
      RESET = 1'b1;
      exp_q.push_back('{is_grant: 1'b0, ch: 2'd0, dack: 4'b0000, mset: 4'b0000});
      @(negedge CLK);
      check("rg_hrq_drop", 32'(HRQ), 32'd0);
      check("rg_grant_valid", 32'(grantValid), 32'd0);
      check("rg_dack", 32'(DACK), 32'h0);
      check("rg_active_channel", 32'(activeChannel), 32'd0);
      RESET = 1'b0; HLDA = 1'b0; DREQ = 4'b0000; ptr_m = 2'd0;

      repeat (60) rand_txn();

      repeat (3) @(negedge CLK);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
